// File: rtl/uart8_if.sv
// Core-side signal bundle for the uart8 8N1 UART: rx status/data and tx request/status.
// master is the core logic (and the serial source feeding rx_in), slave is the UART itself.
interface uart8_if;
    logic       rx_en;
    logic       rx_in;
    logic       rx_busy;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_out;
    logic       tx_en;
    logic       tx_start;
    logic [7:0] tx_in;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_out;

    modport master (
        output rx_en, rx_in, tx_en, tx_start, tx_in,
        input  rx_busy, rx_done, rx_err, rx_out, tx_busy, tx_done, tx_out
    );

    modport slave (
        input  rx_en, rx_in, tx_en, tx_start, tx_in,
        output rx_busy, rx_done, rx_err, rx_out, tx_busy, tx_done, tx_out
    );
endinterface

// File: rtl/uart8.sv
// 8N1 full-duplex UART: 16x oversampling receiver and independent transmitter.
// Define UART8_RX_SYNC_EN to pass rx_in through a 2-flop synchroniser (+2 cycles rx latency).
module uart8 #(
    parameter int unsigned ClockRate    = 12000000,
    parameter int unsigned BaudRate     = 9600,
    parameter int unsigned RxOversample = 16
) (
    input logic    clk,
    input logic    reset,
    uart8_if.slave bus
);
    localparam int unsigned RxDiv  = (ClockRate + (BaudRate * RxOversample) / 2) /
                                     (BaudRate * RxOversample);
    localparam int unsigned TxDiv  = (ClockRate + BaudRate / 2) / BaudRate;
    localparam int unsigned RxDivW = $clog2(RxDiv + 1);
    localparam int unsigned TxDivW = $clog2(TxDiv + 1);
    localparam int unsigned SmpW   = $clog2(RxOversample + 1);

    localparam logic [RxDivW-1:0] RxDivLast = RxDivW'(RxDiv - 1);
    localparam logic [TxDivW-1:0] TxDivLast = TxDivW'(TxDiv - 1);
    localparam logic [SmpW-1:0]   SmpMid    = SmpW'(RxOversample / 2 - 1);
    localparam logic [SmpW-1:0]   SmpLast   = SmpW'(RxOversample - 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxDone} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    logic rxd;

`ifdef UART8_RX_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], bus.rx_in};
        end
    end

    assign rxd = rx_sync[1];
`else
    assign rxd = bus.rx_in;
`endif

    // ---------------- baud dividers ----------------
    logic [RxDivW-1:0] rx_div;
    logic [TxDivW-1:0] tx_div;
    logic              rx_tick;
    logic              tx_tick;
    logic              rx_restart;
    logic              tx_restart;
    rx_state_e         rx_state;
    tx_state_e         tx_state;

    // Dividers realign to the start edge / start request so every bit is timed from it.
    assign rx_restart = (rx_state == RxIdle) && bus.rx_en && !rxd;
    assign tx_restart = (tx_state == TxIdle) && bus.tx_en && bus.tx_start;
    assign rx_tick    = (rx_div == RxDivLast);
    assign tx_tick    = (tx_div == TxDivLast);

    always_ff @(posedge clk) begin
        if (reset || rx_restart || rx_tick) begin
            rx_div <= '0;
        end else begin
            rx_div <= rx_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tx_restart || tx_tick) begin
            tx_div <= '0;
        end else begin
            tx_div <= tx_div + 1'b1;
        end
    end

    // ---------------- receiver ----------------
    logic [SmpW-1:0] rx_smp;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RxIdle;
            rx_smp      <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            bus.rx_busy <= 1'b0;
            bus.rx_done <= 1'b0;
            bus.rx_err  <= 1'b0;
            bus.rx_out  <= '0;
        end else begin
            bus.rx_done <= 1'b0;
            if (!bus.rx_en) begin
                rx_state    <= RxIdle;
                bus.rx_busy <= 1'b0;
            end else begin
                unique case (rx_state)
                    RxIdle: begin
                        bus.rx_busy <= 1'b0;
                        if (!rxd) begin
                            rx_state <= RxStart;
                            rx_smp   <= '0;
                        end
                    end
                    RxStart: begin
                        if (rx_tick) begin
                            if (rx_smp == SmpMid) begin
                                rx_smp <= '0;
                                rx_bit <= '0;
                                if (rxd) begin
                                    rx_state <= RxIdle;  // too short to be a start bit
                                end else begin
                                    rx_state    <= RxData;
                                    bus.rx_busy <= 1'b1;
                                    bus.rx_err  <= 1'b0;
                                end
                            end else begin
                                rx_smp <= rx_smp + 1'b1;
                            end
                        end
                    end
                    RxData: begin
                        if (rx_tick) begin
                            if (rx_smp == SmpLast) begin
                                rx_smp <= '0;
                                rx_sh  <= {rxd, rx_sh[7:1]};
                                rx_bit <= rx_bit + 1'b1;
                                if (rx_bit == 3'd7) begin
                                    rx_state <= RxStop;
                                end
                            end else begin
                                rx_smp <= rx_smp + 1'b1;
                            end
                        end
                    end
                    RxStop: begin
                        if (rx_tick) begin
                            if (rx_smp == SmpLast) begin
                                rx_smp      <= '0;
                                rx_state    <= RxDone;
                                bus.rx_busy <= 1'b0;
                                if (rxd) begin
                                    bus.rx_out  <= rx_sh;
                                    bus.rx_done <= 1'b1;
                                    bus.rx_err  <= 1'b0;
                                end else begin
                                    bus.rx_err <= 1'b1;
                                end
                            end else begin
                                rx_smp <= rx_smp + 1'b1;
                            end
                        end
                    end
                    RxDone: begin
                        // Wait for the line to go idle so a stuck-low line cannot retrigger.
                        bus.rx_busy <= 1'b0;
                        if (rxd) begin
                            rx_state <= RxIdle;
                        end
                    end
                    default: rx_state <= RxIdle;
                endcase
            end
        end
    end

    // ---------------- transmitter ----------------
    logic [7:0] tx_sh;
    logic [2:0] tx_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TxIdle;
            tx_sh       <= '0;
            tx_bit      <= '0;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
            bus.tx_out  <= 1'b1;
        end else begin
            bus.tx_done <= 1'b0;
            if (!bus.tx_en) begin
                tx_state    <= TxIdle;
                bus.tx_busy <= 1'b0;
                bus.tx_out  <= 1'b1;
            end else begin
                unique case (tx_state)
                    TxIdle: begin
                        bus.tx_out  <= 1'b1;
                        bus.tx_busy <= 1'b0;
                        if (bus.tx_start) begin
                            tx_sh       <= bus.tx_in;
                            bus.tx_busy <= 1'b1;
                            bus.tx_out  <= 1'b0;
                            tx_state    <= TxStart;
                        end
                    end
                    TxStart: begin
                        if (tx_tick) begin
                            bus.tx_out <= tx_sh[0];
                            tx_sh      <= {1'b0, tx_sh[7:1]};
                            tx_bit     <= '0;
                            tx_state   <= TxData;
                        end
                    end
                    TxData: begin
                        if (tx_tick) begin
                            if (tx_bit == 3'd7) begin
                                bus.tx_out <= 1'b1;
                                tx_state   <= TxStop;
                            end else begin
                                bus.tx_out <= tx_sh[0];
                                tx_sh      <= {1'b0, tx_sh[7:1]};
                                tx_bit     <= tx_bit + 1'b1;
                            end
                        end
                    end
                    TxStop: begin
                        if (tx_tick) begin
                            bus.tx_done <= 1'b1;
                            bus.tx_busy <= 1'b0;
                            tx_state    <= TxIdle;
                        end
                    end
                    default: tx_state <= TxIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart8.sv
// Self-checking bench for uart8: rx glitch/frame/error/reset cases and tx with loopback.
// Timing is in clock cycles of a 12 MHz clock (default ClockRate).
module tb_uart8;
    localparam int BitCyc    = 1290;  // 107.5 us: 3% slow relative to 9600 baud
    localparam int GlitchCyc = 192;   // 16 us
    localparam int TxBitCyc  = 1250;

    logic clk = 1'b0;
    logic reset;
    logic rx_drv;
    logic loopback;

    uart8_if u_if ();

    assign u_if.rx_in = loopback ? u_if.tx_out : rx_drv;

    uart8 u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    logic       txbit_q[$];
    int         busy_cyc    = 0;
    int         done_cnt    = 0;
    int         tx_done_cnt = 0;
    logic       prev_done   = 1'b0;

    // rx scoreboard: every rx_done must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (u_if.rx_busy) busy_cyc++;
        if (u_if.tx_done) tx_done_cnt++;
        if (u_if.rx_done) begin
            done_cnt++;
            check_eq("rx_done_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("rx_spurious_done", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("rx_out", 32'(u_if.rx_out), 32'(e));
            end
        end
        prev_done = u_if.rx_done;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nbits,
                              input int bitcyc);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_drv = fr[i];
            repeat (bitcyc) @(negedge clk);
        end
    endtask

    initial begin
        int         b0;
        int         d0;
        int         t0;
        logic [9:0] txfr;

        reset         = 1'b1;
        rx_drv        = 1'b1;
        loopback      = 1'b0;
        u_if.rx_en    = 1'b0;
        u_if.tx_en    = 1'b0;
        u_if.tx_start = 1'b0;
        u_if.tx_in    = 8'h00;
        repeat (10) @(negedge clk);
        check_eq("rst_rx_busy", 32'(u_if.rx_busy), 32'd0);
        check_eq("rst_rx_done", 32'(u_if.rx_done), 32'd0);
        check_eq("rst_rx_err",  32'(u_if.rx_err),  32'd0);
        check_eq("rst_rx_out",  32'(u_if.rx_out),  32'h00);
        check_eq("rst_tx_out",  32'(u_if.tx_out),  32'd1);
        check_eq("rst_tx_busy", 32'(u_if.tx_busy), 32'd0);
        reset      = 1'b0;
        u_if.rx_en = 1'b1;
        repeat (5) @(negedge clk);

        // Short low pulse must be rejected at mid start bit.
        b0 = busy_cyc;
        d0 = done_cnt;
        rx_drv = 1'b0;
        repeat (GlitchCyc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (800) @(negedge clk);
        check_eq("glitch_busy", 32'(busy_cyc - b0), 32'd0);
        check_eq("glitch_done", 32'(done_cnt - d0), 32'd0);
        check_eq("glitch_err",  32'(u_if.rx_err),   32'd0);

        // Valid 0x56 at +3% bit time.
        b0 = busy_cyc;
        d0 = done_cnt;
        exp_q.push_back(8'h56);
        send_frame(8'h56, 1'b1, 10, BitCyc);
        check_eq("f1_busy_seen", 32'(busy_cyc > b0),      32'd1);
        check_eq("f1_done_cnt",  32'(done_cnt - d0),      32'd1);
        check_eq("f1_rx_out",    32'(u_if.rx_out),        32'h56);
        check_eq("f1_rx_err",    32'(u_if.rx_err),        32'd0);
        check_eq("f1_q_empty",   32'(exp_q.size()),       32'd0);

        // Back-to-back second frame, aborted by reset mid data.
        send_frame(8'h56, 1'b1, 4, BitCyc);
        check_eq("f2_busy_mid", 32'(u_if.rx_busy), 32'd1);
        reset  = 1'b1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("f2_rst_busy", 32'(u_if.rx_busy), 32'd0);
        check_eq("f2_rst_out",  32'(u_if.rx_out),  32'h00);
        repeat (300) @(negedge clk);

        // Valid 0x3C, then a framing error immediately after it.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 10, BitCyc);
        d0 = done_cnt;
        send_frame(8'hC3, 1'b0, 10, BitCyc);
        b0 = busy_cyc;
        repeat (1000) @(negedge clk);  // line held low after the bad stop bit
        check_eq("ferr_err",       32'(u_if.rx_err),    32'd1);
        check_eq("ferr_out_kept",  32'(u_if.rx_out),    32'h3C);
        check_eq("ferr_no_done",   32'(done_cnt - d0),  32'd0);
        check_eq("ferr_no_retrig", 32'(busy_cyc - b0),  32'd0);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("ferr_persist",   32'(u_if.rx_err),    32'd1);

        // Transmit 0xA5 looped back into the receiver; a start while busy is ignored.
        loopback   = 1'b1;
        u_if.tx_en = 1'b1;
        u_if.tx_in = 8'hA5;
        exp_q.push_back(8'hA5);
        txfr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) txbit_q.push_back(txfr[i]);
        t0 = tx_done_cnt;
        d0 = done_cnt;
        u_if.tx_start = 1'b1;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        repeat (TxBitCyc / 2 - 1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            logic eb;
            eb = txbit_q.pop_front();
            check_eq("tx_bit",  32'(u_if.tx_out),  32'(eb));
            check_eq("tx_busy", 32'(u_if.tx_busy), 32'd1);
            if (i == 3) begin
                u_if.tx_in    = 8'hFF;
                u_if.tx_start = 1'b1;
                @(negedge clk);
                u_if.tx_start = 1'b0;
                repeat (TxBitCyc - 1) @(negedge clk);
            end else begin
                repeat (TxBitCyc) @(negedge clk);
            end
        end
        check_eq("tx_done_cnt",  32'(tx_done_cnt - t0), 32'd1);
        check_eq("tx_busy_end",  32'(u_if.tx_busy),     32'd0);
        check_eq("tx_out_idle",  32'(u_if.tx_out),      32'd1);
        check_eq("lb_done_cnt",  32'(done_cnt - d0),    32'd1);
        check_eq("lb_rx_out",    32'(u_if.rx_out),      32'hA5);
        check_eq("lb_err_clear", 32'(u_if.rx_err),      32'd0);
        check_eq("lb_q_empty",   32'(exp_q.size()),     32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart8.md
Name: uart8

Overview:
- 8N1 full-duplex UART with independent receive and transmit engines.
- Both engines share one clock domain and a baud generator derived from CLOCK_RATE.
- Receiver oversamples rxIn at 16x BAUD_RATE and produces a parallel byte plus busy/done/error status.
- Transmitter serialises a byte on request; it sits between board-level serial pins and core logic.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- RX_OVERSAMPLE, 16, receiver samples per bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rxEn  in  1  receiver enable; low forces receiver idle.
- rxIn  in  1  serial input, idle high.
- rxBusy  out  1  high while a frame is being received.
- rxDone  out  1  one-cycle pulse when rxOut holds a new valid byte.
- rxErr  out  1  framing error flag.
- rxOut  out  8  last received byte.
- txEn  in  1  transmitter enable.
- txStart  in  1  start request, sampled when idle.
- txIn  in  8  byte to send.
- txBusy  out  1  high while a frame is being sent.
- txDone  out  1  one-cycle pulse at end of stop bit.
- txOut  out  1  serial output, idle high.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: rxBusy=0, rxDone=0, rxErr=0, rxOut=0, txBusy=0, txDone=0, txOut=1. All counters cleared and both FSMs go to IDLE. Reset mid-frame aborts the frame immediately.
- Baud ticks:
  - rx tick every round(CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE)) cycles (78 at defaults).
  - tx tick every round(CLOCK_RATE/BAUD_RATE) cycles (1250 at defaults).
  - Dividers are free-running and restart when their engine leaves IDLE.
- Rx FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: rxBusy=0. On rxIn=0 with rxEn=1, go to START and clear the sample counter.
  - START: count 8 rx ticks (mid-bit). If rxIn is then 1, the edge was a glitch: return to IDLE with no done and no err. Otherwise set rxBusy=1 and go to DATA.
  - DATA: sample every 16 rx ticks, LSB first, shifting into a holding register. After 8 bits go to STOP.
  - STOP: sample after 16 rx ticks.
    - rxIn=1: rxOut <= holding register, rxDone pulses 1 cycle, rxErr=0.
    - rxIn=0: rxErr=1, rxOut unchanged, no rxDone.
    - In both cases go to DONE.
  - DONE: rxBusy=0. Return to IDLE only once rxIn=1, so a stuck-low line does not retrigger.
- rxErr persists until the next valid start bit reaches mid-bit.
- rxEn=0 in any rx state forces IDLE with rxBusy=0; rxOut and rxErr are kept.
- rxOut stays stable between frames.
- Timing tolerance: at 16x oversampling the receiver must tolerate ±3% baud mismatch.
- Tx FSM states: IDLE, START, DATA, STOP.
  - IDLE: if txStart=1 and txEn=1, latch txIn, set txBusy=1, drive txOut=0 for one bit.
  - DATA: drive 8 bits LSB first, one bit per tx tick.
  - STOP: drive 1 for one bit, then pulse txDone for 1 cycle, clear txBusy, return to IDLE.
  - txStart while busy is ignored.
  - txEn=0 aborts to IDLE with txOut=1.
- Simultaneous operation: rx and tx run fully independently.

Optional Feature:
- Macro: UART8_RX_SYNC_EN.
- Defined: rxIn passes through a 2-flop synchroniser before the rx FSM, adding 2 cycles of latency to all rx timing.
- Undefined: rxIn is used directly. The source must then be synchronous to clk.

Test Plan:
- Reset for 10 cycles -> rxBusy=0, rxDone=0, rxErr=0, rxOut=0x00, txOut=1.
- rxEn=1; rxIn low for 16 µs then high (glitch) -> no rxBusy, no rxDone, no rxErr.
- Send 0x56 (8'b01010110) 8N1 at 9600 baud with bit time 107.5 µs (+3%) -> rxBusy asserted, rxDone one-cycle pulse, rxOut=0x56, rxErr=0.
- Immediately start a second 0x56 frame after the stop bit -> rxBusy reasserts and bits are sampled correctly; mid-frame reset clears rxBusy and leaves rxOut=0.
- Send a frame with stop bit 0 -> rxErr=1, no rxDone, rxOut keeps its previous value. rxErr clears on the next valid frame.
- txEn=1, txIn=0xA5, pulse txStart -> txOut emits 0,1,0,1,0,0,1,0,1,1 at 104.17 µs per bit. txBusy high throughout, txDone pulses once; a loopback into rxIn yields rxOut=0xA5.
